// File: rtl/uart_pkg.sv
// Definitions shared by the UART Tx and Rx paths: FSM states, the baud divider and the parity rule.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

  localparam int unsigned MAX_FRAME_WIDTH = 64;

  function automatic int unsigned calc_baud_div(input int unsigned clk_freq,
                                                input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

  // Narrower words are zero-extended by the caller; zeros do not change an XOR reduction.
  function automatic logic even_parity(input logic [MAX_FRAME_WIDTH-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_tx_clk_gen.sv
// Free-running baud counter; baud_tick is a one-cycle enable on sys_clk, not a derived clock.
module uart_tx_clk_gen #(
  parameter int unsigned BAUD_DIV = 10
) (
  input  logic sys_clk,
  input  logic reset,
  input  logic clear,
  output logic baud_tick
);

  localparam int unsigned CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge sys_clk) begin
    if (!reset) begin
      count <= '0;
    end else if (clear || count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign baud_tick = (count == LAST);

endmodule

// File: rtl/uart_tx_top.sv
// UART transmitter: start bit, FRAME_WIDTH data bits (index 0 first), even parity, stop bit.
module uart_tx_top
  import uart_pkg::*;
#(
  parameter int unsigned SYS_CLK_FREQ = 200_000_000,
  parameter int unsigned BAUD_RATE    = 19200,
  parameter int unsigned FRAME_WIDTH  = 8
) (
  input  logic                   sys_clk,
  input  logic                   reset,
  input  logic                   uart_tx_start,
  input  logic [0:FRAME_WIDTH-1] uart_tx_din,
  output logic                   uart_tx_dout,
  output logic                   uart_tx_busy,
  output logic                   uart_tx_done
);

  localparam int unsigned BAUD_DIV = calc_baud_div(SYS_CLK_FREQ, BAUD_RATE);
  localparam int unsigned BW       = (FRAME_WIDTH > 1) ? $clog2(FRAME_WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_WIDTH - 1);

  if (BAUD_DIV < 2) begin : g_bad_baud_div
    $error("uart_tx_top: SYS_CLK_FREQ / BAUD_RATE must be at least 2");
  end
  if (FRAME_WIDTH < 1 || FRAME_WIDTH > MAX_FRAME_WIDTH) begin : g_bad_frame_width
    $error("uart_tx_top: FRAME_WIDTH out of range");
  end

  uart_state_t            state;
  logic [0:FRAME_WIDTH-1] shift_reg;
  logic [BW-1:0]          bit_cnt;
  logic                   parity;
  logic                   accept;
  logic                   baud_tick;

  // Clearing on acceptance pins the start-bit phase to the request, independent of history.
  assign accept = (state == IDLE) && uart_tx_start;

  uart_tx_clk_gen #(
    .BAUD_DIV(BAUD_DIV)
  ) u_clk_gen (
    .sys_clk  (sys_clk),
    .reset    (reset),
    .clear    (accept),
    .baud_tick(baud_tick)
  );

  always_ff @(posedge sys_clk) begin
    if (!reset) begin
      state        <= IDLE;
      shift_reg    <= '0;
      bit_cnt      <= '0;
      parity       <= 1'b0;
      uart_tx_dout <= 1'b1;
      uart_tx_busy <= 1'b0;
      uart_tx_done <= 1'b0;
    end else begin
      uart_tx_done <= 1'b0;
      unique case (state)
        IDLE: begin
          uart_tx_dout <= 1'b1;
          if (uart_tx_start) begin
            shift_reg    <= uart_tx_din;
            parity       <= even_parity(MAX_FRAME_WIDTH'(uart_tx_din));
            bit_cnt      <= '0;
            uart_tx_dout <= 1'b0;
            uart_tx_busy <= 1'b1;
            state        <= START;
          end
        end
        START: begin
          if (baud_tick) begin
            uart_tx_dout <= shift_reg[0];
            shift_reg    <= shift_reg << 1;
            state        <= DATA;
          end
        end
        DATA: begin
          if (baud_tick) begin
            if (bit_cnt == LAST_BIT) begin
              uart_tx_dout <= parity;
              state        <= PARITY;
            end else begin
              uart_tx_dout <= shift_reg[0];
              shift_reg    <= shift_reg << 1;
              bit_cnt      <= bit_cnt + 1'b1;
            end
          end
        end
        PARITY: begin
          if (baud_tick) begin
            uart_tx_dout <= 1'b1;
            state        <= STOP;
          end
        end
        STOP: begin
          if (baud_tick) begin
            uart_tx_busy <= 1'b0;
            uart_tx_done <= 1'b1;
            state        <= IDLE;
          end
        end
        default: begin
          uart_tx_dout <= 1'b1;
          uart_tx_busy <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule
